// File: rtl/shift_add_seq.sv
// Shift-add window accumulator: each runtime weight is split into signed power-of-two terms.
// Optional macro SHIFT_ADD_SEQ_FALLBACK_MUL_EN adds a FIX state that multiplies out any leftover residue.
module shift_add_seq #(
  parameter int BITS  = 17,
  parameter int WBITS = 16,
  parameter int TAPS  = 9,
  parameter int DEPTH = 2,
  parameter int ACC_W = 2*BITS + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAPS*BITS-1:0]     data_in,
  input  logic [TAPS*WBITS-1:0]    weight_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  data_out,
  output logic                     out_inexact
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int DW = $clog2(DEPTH+1);
  localparam int KW = $clog2(WBITS+1);
  localparam int RW = WBITS + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef SHIFT_ADD_SEQ_FALLBACK_MUL_EN
    S_FIX  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [TAPS*BITS-1:0]     pix_q;
  logic [TAPS*WBITS-1:0]    wgt_q;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [TW-1:0]            tap, tap_nxt;
  logic [DW-1:0]            term, term_nxt;
  logic signed [RW-1:0]     r, r_nxt, r_after, pow_k, nxt_w;
  logic                     inexact, inexact_nxt, advance;
  logic [RW-1:0]            mag;
  logic [KW-1:0]            k_sel;
  logic signed [BITS-1:0]   cur_pix;
  logic signed [ACC_W-1:0]  pix_ext, shifted;
`ifdef SHIFT_ADD_SEQ_FALLBACK_MUL_EN
  logic signed [ACC_W-1:0]  r_ext;
  assign r_ext = {{(ACC_W-RW){r[RW-1]}}, r};
`endif

  assign in_ready = (state == S_IDLE);
  assign cur_pix  = pix_q[tap*BITS +: BITS];
  assign pix_ext  = {{(ACC_W-BITS){cur_pix[BITS-1]}}, cur_pix};

  always_comb begin
    nxt_w = '0;
    if (tap != TW'(TAPS-1))
      nxt_w = {{(RW-WBITS){wgt_q[(tap+1)*WBITS + WBITS-1]}}, wgt_q[(tap+1)*WBITS +: WBITS]};
  end

  // Nearest power of two to |r|; scanning upward with <= lets ties land on the larger exponent.
  always_comb begin
    logic [RW-1:0] p, d, best;
    best  = '1;
    k_sel = '0;
    mag   = r[RW-1] ? RW'(-r) : RW'(r);
    for (int i = 0; i <= WBITS; i++) begin
      p = RW'(1) << i;
      d = (mag >= p) ? (mag - p) : (p - mag);
      if (d <= best) begin
        best  = d;
        k_sel = KW'(i);
      end
    end
  end

  assign pow_k   = RW'(1) << k_sel;
  assign shifted = pix_ext <<< k_sel;
  assign r_after = r[RW-1] ? (r + pow_k) : (r - pow_k);

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    tap_nxt     = tap;
    term_nxt    = term;
    r_nxt       = r;
    inexact_nxt = inexact;
    advance     = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt   = S_RUN;
          acc_nxt     = '0;
          tap_nxt     = '0;
          term_nxt    = '0;
          r_nxt       = {{(RW-WBITS){weight_in[WBITS-1]}}, weight_in[WBITS-1:0]};
          inexact_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (r == '0) begin
          advance = 1'b1;
        end else begin
          acc_nxt  = r[RW-1] ? (acc - shifted) : (acc + shifted);
          r_nxt    = r_after;
          term_nxt = term + DW'(1);
          if (r_after == '0) begin
            advance = 1'b1;
          end else if (term_nxt == DW'(DEPTH)) begin
`ifdef SHIFT_ADD_SEQ_FALLBACK_MUL_EN
            state_nxt = S_FIX;
`else
            inexact_nxt = 1'b1;
            advance     = 1'b1;
`endif
          end
        end
      end
`ifdef SHIFT_ADD_SEQ_FALLBACK_MUL_EN
      S_FIX: begin
        acc_nxt = acc + pix_ext * r_ext;
        advance = 1'b1;
      end
`endif
      S_DONE: begin
        if (out_valid && out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (advance) begin
      term_nxt = '0;
      r_nxt    = nxt_w;
      if (tap == TW'(TAPS-1)) begin
        state_nxt = S_DONE;
      end else begin
        tap_nxt   = tap + TW'(1);
        state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pix_q       <= '0;
      wgt_q       <= '0;
      acc         <= '0;
      tap         <= '0;
      term        <= '0;
      r           <= '0;
      inexact     <= 1'b0;
      out_valid   <= 1'b0;
      data_out    <= '0;
      out_inexact <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      tap     <= tap_nxt;
      term    <= term_nxt;
      r       <= r_nxt;
      inexact <= inexact_nxt;
      if (state == S_IDLE && in_valid) begin
        pix_q <= data_in;
        wgt_q <= weight_in;
      end
      // Result registers follow DONE by one edge and then hold until taken.
      if (state == S_DONE) begin
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end else begin
          out_valid   <= 1'b1;
          data_out    <= acc;
          out_inexact <= inexact;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_add_seq.sv
// Directed bench for shift_add_seq against an arithmetic power-of-two decomposition model.
module tb_shift_add_seq;
  localparam int BITS  = 17;
  localparam int WBITS = 16;
  localparam int TAPS  = 9;
  localparam int DEPTH = 2;
  localparam int ACC_W = 2*BITS + $clog2(TAPS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_inexact;
  logic [TAPS*BITS-1:0]    data_in = '0;
  logic [TAPS*WBITS-1:0]   weight_in = '0;
  logic signed [ACC_W-1:0] data_out;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pix_a[TAPS];
  int wgt_a[TAPS];
  longint exp_data;
  bit exp_inex;
  bit armed = 1'b0;

  shift_add_seq #(.BITS(BITS), .WBITS(WBITS), .TAPS(TAPS), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weight_in(weight_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int best_k(input longint r);
    longint m, d, bd;
    int bk;
    m = (r < 0) ? -r : r;
    bk = 0;
    bd = 0;
    for (int i = 0; i <= WBITS; i++) begin
      d = m - (longint'(1) << i);
      if (d < 0) d = -d;
      if (i == 0 || d <= bd) begin
        bd = d;
        bk = i;
      end
    end
    return bk;
  endfunction

  task automatic model(output longint sum, output bit inex, output int cost);
    sum = 0;
    inex = 1'b0;
    cost = 0;
    for (int t = 0; t < TAPS; t++) begin
      longint r, tv;
      int n;
      r = wgt_a[t];
      n = 0;
      if (r == 0) begin
        cost++;
      end else begin
        while (r != 0 && n < DEPTH) begin
          tv = longint'(1) << best_k(r);
          if (r < 0) tv = -tv;
          sum += longint'(pix_a[t]) * tv;
          r -= tv;
          n++;
        end
        cost += n;
        if (r != 0) begin
`ifdef SHIFT_ADD_SEQ_FALLBACK_MUL_EN
          sum += longint'(pix_a[t]) * r;
          cost++;
`else
          inex = 1'b1;
`endif
        end
      end
    end
  endtask

  // Result and handshake checks on every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n && armed && out_valid) begin
      check("data_out_vs_model", longint'(data_out), exp_data);
      check("inexact_vs_model", longint'(out_inexact), longint'(exp_inex));
      check("in_ready_low_in_done", longint'(in_ready), 0);
    end
  end

  task automatic start_window(input string name, input longint lit_data, input bit lit_inex,
                              input int lit_cost, input int bp, output int t0);
    longint s;
    bit ix;
    int c, w;
    armed = 1'b0;
    model(s, ix, c);
    check({name, "_model_data"}, s, lit_data);
    check({name, "_model_inexact"}, longint'(ix), longint'(lit_inex));
    check({name, "_model_cost"}, c, lit_cost);
    exp_data = lit_data;
    exp_inex = lit_inex;
    for (int i = 0; i < TAPS; i++) begin
      data_in[i*BITS +: BITS]    = pix_a[i][BITS-1:0];
      weight_in[i*WBITS +: WBITS] = wgt_a[i][WBITS-1:0];
    end
    out_ready = (bp == 0);
    armed = 1'b1;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({name, "_ready_before_accept"}, longint'(in_ready), 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic finish_window(input string name, input int t0, input longint lit_data,
                               input bit lit_inex, input int lit_cost, input int bp);
    int w;
    w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check({name, "_out_valid_timeout"}, longint'(out_valid), 1);
    check({name, "_latency"}, cyc - t0, lit_cost + 1);
    check({name, "_data"}, longint'(data_out), lit_data);
    check({name, "_inexact"}, longint'(out_inexact), longint'(lit_inex));
    repeat (bp) begin
      @(posedge clk);
      #1;
    end
    if (bp > 0) check({name, "_held_valid"}, longint'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_handshake_valid_low"}, longint'(out_valid), 0);
    check({name, "_handshake_idle"}, longint'(in_ready), 1);
  endtask

  task automatic run_window(input string name, input longint lit_data, input bit lit_inex,
                            input int lit_cost, input int bp);
    int t0;
    start_window(name, lit_data, lit_inex, lit_cost, bp, t0);
    finish_window(name, t0, lit_data, lit_inex, lit_cost, bp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_data_out", longint'(data_out), 0);
    check("reset_inexact", longint'(out_inexact), 0);
    check("reset_in_ready", longint'(in_ready), 1);
    rst_n = 1'b1;

    pix_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    wgt_a = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_window("ones", 45, 1'b0, 9, 0);

    pix_a = '{7, 100, -3, 55, 1, 2, 3, 4, 5};
    wgt_a = '{3, 0, 0, 0, 0, 0, 0, 0, 0};
    run_window("w3", 21, 1'b0, 10, 0);

    pix_a = '{-5, -5, -5, -5, -5, -5, -5, -5, -5};
    pix_a[0] = 5;
    wgt_a = '{-6, 0, 0, 0, 0, 0, 0, 0, 0};
    run_window("wm6", -30, 1'b0, 10, 0);

    pix_a = '{3, -2, 9, 4, -5, 1, 1, 1, 1};
    wgt_a = '{5, -1, 0, 16, 7, 0, 0, 0, 0};
    run_window("mixed_bp", 46, 1'b0, 11, 20);

    pix_a = '{-65536, 65535, 0, 0, 0, 0, 0, 0, 0};
    wgt_a = '{-32768, 32767, 0, 0, 0, 0, 0, 0, 0};
    run_window("extremes", 64'd4294868993, 1'b0, 10, 0);

    pix_a = '{2, 9, 9, 9, 9, 9, 9, 9, 9};
    wgt_a = '{11, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef SHIFT_ADD_SEQ_FALLBACK_MUL_EN
    run_window("w11", 22, 1'b0, 11, 0);
`else
    run_window("w11", 24, 1'b1, 10, 0);
`endif

    pix_a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    wgt_a = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    start_window("rst_mid", 45, 1'b0, 9, 0, t0);
    armed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", longint'(out_valid), 0);
    check("rst_mid_data_out", longint'(data_out), 0);
    check("rst_mid_inexact", longint'(out_inexact), 0);
    check("rst_mid_idle", longint'(in_ready), 1);
    rst_n = 1'b1;
    run_window("after_rst", 45, 1'b0, 9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
